cpu_hazard_fwd_unit: RTL and testbench
======================================

Name: cpu_hazard_fwd_unit

Overview:
- Parametrised successor to the 5-stage pipeline's stall/flush hazard unit.
- Adds per-read-port forwarding select, a compile-time forwarding/stall-only mode, load-use detection, and halt freeze.
- Adds event-vs-cycle hazard statistics with saturating counters.
- Sits beside the IF/ID/EX/MEM stages; drives stage stall/flush bits and EX operand mux selects.

Parameters:
- RA_W, 5, register-number width.
- NRD, 2, number of ID read ports checked.
- FWD_EN, 1, 1 = forward where possible; 0 = stall-only (legacy behaviour).
- CNT_W, 32, statistics counter width.

Ports:
- clk  in  1  pipeline clock.
- clr  in  1  asynchronous active-low reset.
- rd_num_id  in  NRD*RA_W  ID read register numbers; port i is bits [i*RA_W +: RA_W].
- rd_use_id  in  NRD  port i actually read by the ID instruction.
- wr_en_ex  in  1  EX instruction writes a register.
- wr_num_ex  in  RA_W  EX destination.
- mem_rd_ex  in  1  EX instruction is a load.
- wr_en_mem  in  1  MEM instruction writes a register.
- wr_num_mem  in  RA_W  MEM destination.
- pc_inc_ex  in  2  00 sequential, 01 branch taken, 10 jump, 11 treated as jump.
- halt  in  1  CPU halted.
- cnt_clr  in  1  synchronous counter clear.
- stalls  out  5  stage stall bits: [0]IF [1]ID [2]EX [3]MEM [4]WB.
- flushs  out  5  stage flush bits, same indices.
- fwd_sel  out  2*NRD  per port: 00 regfile, 01 from EX, 10 from MEM.
- data_hazard_count  out  CNT_W  stall events.
- data_hazard_ex_count  out  CNT_W  events first detected against EX.
- data_hazard_mem_count  out  CNT_W  events first detected against MEM.
- stall_cycle_count  out  CNT_W  cycles with a data stall.
- control_hazard_count  out  CNT_W  branch + jump flushes.
- control_hazard_branch_count  out  CNT_W  taken branches.
- control_hazard_jump_count  out  CNT_W  jumps.

Behaviour:
- Per-port match terms:
  - mex_i = rd_use_id[i] & wr_en_ex & rd_num_i==wr_num_ex & rd_num_i!=0.
  - mmem_i = rd_use_id[i] & wr_en_mem & rd_num_i==wr_num_mem & rd_num_i!=0.
  - Register 0 never matches.
- FWD_EN=1:
  - Port needs stall if mex_i & mem_rd_ex (load-use).
  - Else fwd_sel_i = 01 if mex_i, else 10 if mmem_i, else 00. EX has priority over MEM.
- FWD_EN=0:
  - Port needs stall if mex_i | mmem_i.
  - fwd_sel is constant 0.
- Data stall (any port needs stall):
  - stalls[0] = stalls[1] = 1.
  - flushs[2] = 1 (bubble into ID->EX).
  - All other bits 0.
- Control hazard (pc_inc_ex != 00):
  - flushs[1] = flushs[2] = 1; all stalls = 0.
  - Overrides a simultaneous data stall, which is neither counted nor asserted that cycle.
- halt:
  - stalls = 5'b11111, flushs = 0, fwd_sel = 0.
  - All counters hold, including against cnt_clr.
  - Overrides both hazard types.
- stalls, flushs and fwd_sel are combinational, zero latency. They are forced to 0 while clr is low.
- Event tracking:
  - Register prev_stall holds last cycle's asserted data stall.
  - Event = data stall asserted & !prev_stall.
  - At an event: data_hazard_count += 1. data_hazard_ex_count += 1 if any stalling port has mex_i; otherwise data_hazard_mem_count += 1.
  - stall_cycle_count += 1 every cycle a data stall is asserted.
- control_hazard_count += 1 per cycle with pc_inc_ex != 00.
  - Branch count for 01; jump count for 10 or 11.
- All counters:
  - Saturate at 2^CNT_W-1; no wrap.
  - Update on posedge clk.
  - cnt_clr zeroes all counters and prev_stall next edge, taking priority over increments.
- Reset (clr low, asynchronous): all counters = 0, prev_stall = 0; outputs 0 until clr returns high.
- Reset mid-stall: the stall drops immediately. After release, a still-present hazard counts as a new event.

Test Plan:
- FWD_EN=1, ID rd_num0=8, EX wr_en=1, wr_num=8, mem_rd_ex=0 -> fwd_sel=01, stalls=0, no counter change.
- Same with mem_rd_ex=1 for 1 cycle, then the producer moves to MEM -> cycle 1: stalls=00011, flushs=00100; cycle 2: fwd_sel port0=10. data_hazard_count=1, ex_count=1, stall_cycle_count=1.
- FWD_EN=0, dependence on EX held 2 cycles (EX then MEM) -> stalls=00011 both cycles; data_hazard_count=1, ex_count=1, mem_count=0, stall_cycle_count=2.
- rd_num=0 with matching writes, plus rd_use=0 with rd_num=5 matching -> no stall, fwd_sel=00.
- pc_inc_ex=01 during a load-use condition -> flushs=00110, stalls=0; branch_count=1, control_count=1, data counts unchanged. pc_inc_ex=11 -> jump_count increments.
- CNT_W=3, 9 consecutive jumps -> jump_count=7. Then halt=1 -> stalls=11111 and counts frozen. Then cnt_clr with halt=0 -> all counts 0. clr pulsed low mid-stall -> outputs 0 asynchronously.

Source files
------------

// File: rtl/cpu_hazard_fwd_unit.sv
`default_nettype none
// ==========================================================================
// cpu_hazard_fwd_unit : pipeline stall/flush/forward control + hazard stats
// Revision 1.0 - initial release
// ==========================================================================
module cpu_hazard_fwd_unit #(
  parameter int RA_W   = 5,
  parameter int NRD    = 2,
  parameter bit FWD_EN = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NRD*RA_W-1:0] rd_num_id,
  input  logic [NRD-1:0]      rd_use_id,
  input  logic                wr_en_ex,
  input  logic [RA_W-1:0]     wr_num_ex,
  input  logic                mem_rd_ex,
  input  logic                wr_en_mem,
  input  logic [RA_W-1:0]     wr_num_mem,
  input  logic [1:0]          pc_inc_ex,
  input  logic                halt,
  input  logic                cnt_clr,
  output logic [4:0]          stalls,
  output logic [4:0]          flushs,
  output logic [2*NRD-1:0]    fwd_sel,
  output logic [CNT_W-1:0]    data_hazard_count,
  output logic [CNT_W-1:0]    data_hazard_ex_count,
  output logic [CNT_W-1:0]    data_hazard_mem_count,
  output logic [CNT_W-1:0]    stall_cycle_count,
  output logic [CNT_W-1:0]    control_hazard_count,
  output logic [CNT_W-1:0]    control_hazard_branch_count,
  output logic [CNT_W-1:0]    control_hazard_jump_count
);

  localparam int NCNT = 7;
  localparam int C_DH     = 0;
  localparam int C_DH_EX  = 1;
  localparam int C_DH_MEM = 2;
  localparam int C_SC     = 3;
  localparam int C_CH     = 4;
  localparam int C_CH_BR  = 5;
  localparam int C_CH_JP  = 6;
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_MAX = '1;

  logic [NRD-1:0]   w_mex;
  logic [NRD-1:0]   w_mmem;
  logic [NRD-1:0]   w_need_stall;
  logic [2*NRD-1:0] w_fsel;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [RA_W-1:0] w_rn;
    assign w_rn      = rd_num_id[g*RA_W +: RA_W];
    assign w_mex[g]  = rd_use_id[g] & wr_en_ex  & (w_rn == wr_num_ex)  & (w_rn != '0);
    assign w_mmem[g] = rd_use_id[g] & wr_en_mem & (w_rn == wr_num_mem) & (w_rn != '0);

    if (FWD_EN) begin : g_fwd
      // Only a load in EX cannot be bypassed; EX result wins over the older MEM one.
      assign w_need_stall[g] = w_mex[g] & mem_rd_ex;
      assign w_fsel[2*g +: 2] = w_need_stall[g] ? 2'b00 :
                                w_mex[g]        ? 2'b01 :
                                w_mmem[g]       ? 2'b10 : 2'b00;
    end else begin : g_stall_only
      assign w_need_stall[g]  = w_mex[g] | w_mmem[g];
      assign w_fsel[2*g +: 2] = 2'b00;
    end
  end

  logic w_ctrl;
  logic w_data_stall;
  logic w_ex_event;
  logic w_event;
  logic prev_stall_q;
  logic prev_stall_d;

  assign w_ctrl       = |pc_inc_ex;
  assign w_data_stall = clr & ~halt & ~w_ctrl & (|w_need_stall);
  assign w_ex_event   = |(w_need_stall & w_mex);
  assign w_event      = w_data_stall & ~prev_stall_q;
  assign prev_stall_d = cnt_clr ? 1'b0 : w_data_stall;

  always_comb begin
    stalls  = 5'b00000;
    flushs  = 5'b00000;
    fwd_sel = '0;
    if (clr) begin
      if (halt) begin
        stalls = 5'b11111;
      end else if (w_ctrl) begin
        flushs  = 5'b00110;
        fwd_sel = w_fsel;
      end else begin
        fwd_sel = w_fsel;
        if (w_data_stall) begin
          stalls = 5'b00011;
          flushs = 5'b00100;
        end
      end
    end
  end

  logic [NCNT-1:0]             w_inc;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_q;
  logic [NCNT-1:0][CNT_W-1:0]  cnt_d;

  always_comb begin
    w_inc           = '0;
    w_inc[C_DH]     = w_event;
    w_inc[C_DH_EX]  = w_event & w_ex_event;
    w_inc[C_DH_MEM] = w_event & ~w_ex_event;
    w_inc[C_SC]     = w_data_stall;
    w_inc[C_CH]     = w_ctrl;
    w_inc[C_CH_BR]  = (pc_inc_ex == 2'b01);
    w_inc[C_CH_JP]  = pc_inc_ex[1];
  end

  // Halt freezes the statistics outright, so it outranks the clear as well.
  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NCNT; k++) begin
      if (!halt) begin
        if (cnt_clr) begin
          cnt_d[k] = '0;
        end else if (w_inc[k] && (cnt_q[k] != C_MAX)) begin
          cnt_d[k] = cnt_q[k] + C_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q        <= '0;
      prev_stall_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      prev_stall_q <= prev_stall_d;
    end
  end

  assign data_hazard_count           = cnt_q[C_DH];
  assign data_hazard_ex_count        = cnt_q[C_DH_EX];
  assign data_hazard_mem_count       = cnt_q[C_DH_MEM];
  assign stall_cycle_count           = cnt_q[C_SC];
  assign control_hazard_count        = cnt_q[C_CH];
  assign control_hazard_branch_count = cnt_q[C_CH_BR];
  assign control_hazard_jump_count   = cnt_q[C_CH_JP];

endmodule
`default_nettype wire

// File: tb/tb_cpu_hazard_fwd_unit.sv
`default_nettype none
// ==========================================================================
// tb_cpu_hazard_fwd_unit : directed vector bench for cpu_hazard_fwd_unit
// Revision 1.0 - initial release
// ==========================================================================
module tb_cpu_hazard_fwd_unit;

  logic       clk;
  logic       clr;
  logic [9:0] rd_num_id;
  logic [1:0] rd_use_id;
  logic       wr_en_ex;
  logic [4:0] wr_num_ex;
  logic       mem_rd_ex;
  logic       wr_en_mem;
  logic [4:0] wr_num_mem;
  logic [1:0] pc_inc_ex;
  logic       halt;
  logic       cnt_clr;

  logic [4:0]  f_st, f_fl, s_st, s_fl, t_st, t_fl;
  logic [3:0]  f_fs, s_fs, t_fs;
  logic [31:0] f_c [7];
  logic [31:0] s_c [7];
  logic [2:0]  t_c [7];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cpu_hazard_fwd_unit #(.FWD_EN(1'b1), .CNT_W(32)) u_fwd (
    .clk(clk), .clr(clr), .rd_num_id(rd_num_id), .rd_use_id(rd_use_id),
    .wr_en_ex(wr_en_ex), .wr_num_ex(wr_num_ex), .mem_rd_ex(mem_rd_ex),
    .wr_en_mem(wr_en_mem), .wr_num_mem(wr_num_mem), .pc_inc_ex(pc_inc_ex),
    .halt(halt), .cnt_clr(cnt_clr), .stalls(f_st), .flushs(f_fl), .fwd_sel(f_fs),
    .data_hazard_count(f_c[0]), .data_hazard_ex_count(f_c[1]),
    .data_hazard_mem_count(f_c[2]), .stall_cycle_count(f_c[3]),
    .control_hazard_count(f_c[4]), .control_hazard_branch_count(f_c[5]),
    .control_hazard_jump_count(f_c[6]));

  cpu_hazard_fwd_unit #(.FWD_EN(1'b0), .CNT_W(32)) u_stall (
    .clk(clk), .clr(clr), .rd_num_id(rd_num_id), .rd_use_id(rd_use_id),
    .wr_en_ex(wr_en_ex), .wr_num_ex(wr_num_ex), .mem_rd_ex(mem_rd_ex),
    .wr_en_mem(wr_en_mem), .wr_num_mem(wr_num_mem), .pc_inc_ex(pc_inc_ex),
    .halt(halt), .cnt_clr(cnt_clr), .stalls(s_st), .flushs(s_fl), .fwd_sel(s_fs),
    .data_hazard_count(s_c[0]), .data_hazard_ex_count(s_c[1]),
    .data_hazard_mem_count(s_c[2]), .stall_cycle_count(s_c[3]),
    .control_hazard_count(s_c[4]), .control_hazard_branch_count(s_c[5]),
    .control_hazard_jump_count(s_c[6]));

  cpu_hazard_fwd_unit #(.FWD_EN(1'b1), .CNT_W(3)) u_sat (
    .clk(clk), .clr(clr), .rd_num_id(rd_num_id), .rd_use_id(rd_use_id),
    .wr_en_ex(wr_en_ex), .wr_num_ex(wr_num_ex), .mem_rd_ex(mem_rd_ex),
    .wr_en_mem(wr_en_mem), .wr_num_mem(wr_num_mem), .pc_inc_ex(pc_inc_ex),
    .halt(halt), .cnt_clr(cnt_clr), .stalls(t_st), .flushs(t_fl), .fwd_sel(t_fs),
    .data_hazard_count(t_c[0]), .data_hazard_ex_count(t_c[1]),
    .data_hazard_mem_count(t_c[2]), .stall_cycle_count(t_c[3]),
    .control_hazard_count(t_c[4]), .control_hazard_branch_count(t_c[5]),
    .control_hazard_jump_count(t_c[6]));

  typedef struct {
    logic [4:0] rn1, rn0;
    logic [1:0] use_m;
    logic       exwe;
    logic [4:0] exn;
    logic       ld;
    logic       mwe;
    logic [4:0] mn;
    logic [1:0] pc;
    logic       hlt;
    logic [4:0] e_fst, e_ffl;
    logic [3:0] e_ffs;
    logic [4:0] e_sst, e_sfl;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mk(input logic [4:0] rn1, rn0, input logic [1:0] use_m,
                              input logic exwe, input logic [4:0] exn, input logic ld,
                              input logic mwe, input logic [4:0] mn, input logic [1:0] pc,
                              input logic hlt, input logic [4:0] e_fst, e_ffl,
                              input logic [3:0] e_ffs, input logic [4:0] e_sst, e_sfl);
    vec_t v;
    v.rn1 = rn1; v.rn0 = rn0; v.use_m = use_m; v.exwe = exwe; v.exn = exn; v.ld = ld;
    v.mwe = mwe; v.mn = mn; v.pc = pc; v.hlt = hlt;
    v.e_fst = e_fst; v.e_ffl = e_ffl; v.e_ffs = e_ffs; v.e_sst = e_sst; v.e_sfl = e_sfl;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rd_num_id  = {v.rn1, v.rn0};
    rd_use_id  = v.use_m;
    wr_en_ex   = v.exwe;
    wr_num_ex  = v.exn;
    mem_rd_ex  = v.ld;
    wr_en_mem  = v.mwe;
    wr_num_mem = v.mn;
    pc_inc_ex  = v.pc;
    halt       = v.hlt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // inst: 0 = forwarding, 1 = stall-only, 2 = 3-bit saturating
  task automatic chk_cnt(input string tag, input int inst, input int dh, input int ex,
                         input int mm, input int sc, input int ch, input int br, input int jp);
    logic [31:0] a [7];
    int e [7];
    string nm [7];
    e = '{dh, ex, mm, sc, ch, br, jp};
    nm = '{"dh", "dh_ex", "dh_mem", "stall_cyc", "ctrl", "branch", "jump"};
    for (int k = 0; k < 7; k++) begin
      case (inst)
        0:       a[k] = f_c[k];
        1:       a[k] = s_c[k];
        default: a[k] = {29'd0, t_c[k]};
      endcase
      chk($sformatf("%s.%0d.%s", tag, inst, nm[k]), a[k], e[k]);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t idle, lu, fw_mem, sv;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle   = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    lu     = mk(0, 8, 2'b01, 1, 8, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    fw_mem = mk(0, 8, 2'b01, 0, 0, 0, 1, 8, 2'b00, 0, 0, 0, 0, 0, 0);

    //            rn1 rn0 use  exwe exn ld mwe mn  pc    hlt  F.st      F.fl      F.fs     S.st      S.fl
    tbl[0]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0,  2'b00, 0, 5'b00000, 5'b00000, 4'b0000, 5'b00000, 5'b00000);
    tbl[1]  = mk(0, 8, 2'b01, 1, 8, 0, 0, 0,  2'b00, 0, 5'b00000, 5'b00000, 4'b0001, 5'b00011, 5'b00100);
    tbl[2]  = mk(0, 8, 2'b01, 1, 8, 1, 0, 0,  2'b00, 0, 5'b00011, 5'b00100, 4'b0000, 5'b00011, 5'b00100);
    tbl[3]  = mk(0, 8, 2'b01, 0, 0, 0, 1, 8,  2'b00, 0, 5'b00000, 5'b00000, 4'b0010, 5'b00011, 5'b00100);
    tbl[4]  = mk(0, 8, 2'b01, 1, 8, 0, 1, 8,  2'b00, 0, 5'b00000, 5'b00000, 4'b0001, 5'b00011, 5'b00100);
    tbl[5]  = mk(9, 8, 2'b11, 1, 8, 0, 1, 9,  2'b00, 0, 5'b00000, 5'b00000, 4'b1001, 5'b00011, 5'b00100);
    tbl[6]  = mk(0, 0, 2'b11, 1, 0, 1, 1, 0,  2'b00, 0, 5'b00000, 5'b00000, 4'b0000, 5'b00000, 5'b00000);
    tbl[7]  = mk(0, 5, 2'b00, 1, 5, 1, 1, 5,  2'b00, 0, 5'b00000, 5'b00000, 4'b0000, 5'b00000, 5'b00000);
    tbl[8]  = mk(0, 8, 2'b01, 1, 8, 1, 0, 0,  2'b01, 0, 5'b00000, 5'b00110, 4'b0000, 5'b00000, 5'b00110);
    tbl[9]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0,  2'b10, 0, 5'b00000, 5'b00110, 4'b0000, 5'b00000, 5'b00110);
    tbl[10] = mk(0, 8, 2'b01, 1, 8, 1, 0, 0,  2'b11, 1, 5'b11111, 5'b00000, 4'b0000, 5'b11111, 5'b00000);
    tbl[11] = mk(9, 8, 2'b11, 1, 8, 0, 1, 9,  2'b00, 1, 5'b11111, 5'b00000, 4'b0000, 5'b11111, 5'b00000);
    tbl[12] = mk(7, 8, 2'b11, 1, 7, 1, 1, 8,  2'b00, 0, 5'b00011, 5'b00100, 4'b0010, 5'b00011, 5'b00100);
    tbl[13] = mk(3, 0, 2'b10, 1, 3, 0, 0, 0,  2'b00, 0, 5'b00000, 5'b00000, 4'b0100, 5'b00011, 5'b00100);
    tbl[14] = mk(0, 8, 2'b01, 1, 9, 1, 1, 10, 2'b00, 0, 5'b00000, 5'b00000, 4'b0000, 5'b00000, 5'b00000);

    // Reset: outputs forced low even with a halt and a load-use hazard present.
    clr = 1'b0;
    cnt_clr = 1'b0;
    sv = lu;
    sv.hlt = 1'b1;
    drive(sv);
    #2;
    chk("rst_halt.stalls", f_st, 5'b00000);
    drive(lu);
    #1;
    chk("rst_lu.stalls", f_st, 5'b00000);
    chk("rst_lu.flushs", f_fl, 5'b00000);
    chk("rst_lu.fwd_sel", f_fs, 4'b0000);
    chk_cnt("rst", 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    @(negedge clk);
    clr = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("vec%0d.f_stalls", i), f_st, tbl[i].e_fst);
      chk($sformatf("vec%0d.f_flushs", i), f_fl, tbl[i].e_ffl);
      chk($sformatf("vec%0d.f_fwd_sel", i), f_fs, tbl[i].e_ffs);
      chk($sformatf("vec%0d.s_stalls", i), s_st, tbl[i].e_sst);
      chk($sformatf("vec%0d.s_flushs", i), s_fl, tbl[i].e_sfl);
      chk($sformatf("vec%0d.s_fwd_sel", i), s_fs, 4'b0000);
      tick();
    end

    drive(idle);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    for (int n = 0; n < 3; n++) chk_cnt("clr0", n, 0, 0, 0, 0, 0, 0, 0);

    // Load-use for one cycle, then the producer reaches MEM.
    drive(lu);
    #1;
    chk("lu.stalls", f_st, 5'b00011);
    chk("lu.flushs", f_fl, 5'b00100);
    tick();
    chk_cnt("lu", 0, 1, 1, 0, 1, 0, 0, 0);
    drive(fw_mem);
    #1;
    chk("lu_mem.fwd_sel", f_fs, 4'b0010);
    chk("lu_mem.stalls", f_st, 5'b00000);
    chk("lu_mem.s_stalls", s_st, 5'b00011);
    tick();
    chk_cnt("lu_mem", 0, 1, 1, 0, 1, 0, 0, 0);
    chk_cnt("lu_mem", 1, 1, 1, 0, 2, 0, 0, 0);
    chk_cnt("lu_mem", 2, 1, 1, 0, 1, 0, 0, 0);

    drive(idle);
    tick();
    drive(fw_mem);
    tick();
    chk_cnt("mem_ev", 1, 2, 1, 1, 3, 0, 0, 0);
    chk_cnt("mem_ev", 0, 1, 1, 0, 1, 0, 0, 0);

    // Branch taken during a load-use: flush wins, no data accounting.
    sv = lu;
    sv.pc = 2'b01;
    drive(sv);
    #1;
    chk("br_lu.stalls", f_st, 5'b00000);
    chk("br_lu.flushs", f_fl, 5'b00110);
    tick();
    chk_cnt("br", 0, 1, 1, 0, 1, 1, 1, 0);
    sv = idle;
    sv.pc = 2'b11;
    drive(sv);
    tick();
    chk_cnt("jp11", 0, 1, 1, 0, 1, 2, 1, 1);

    sv.pc = 2'b10;
    drive(sv);
    for (int n = 0; n < 9; n++) tick();
    chk_cnt("jp9", 0, 1, 1, 0, 1, 11, 1, 10);
    chk_cnt("jp9", 2, 1, 1, 0, 1, 7, 1, 7);
    chk_cnt("jp9", 1, 2, 1, 1, 3, 11, 1, 10);

    // Halt freezes counters, even against cnt_clr.
    sv = lu;
    sv.pc = 2'b10;
    sv.hlt = 1'b1;
    drive(sv);
    #1;
    chk("halt.stalls", f_st, 5'b11111);
    chk("halt.flushs", f_fl, 5'b00000);
    chk("halt.fwd_sel", f_fs, 4'b0000);
    tick();
    cnt_clr = 1'b1;
    tick();
    chk_cnt("halt", 2, 1, 1, 0, 1, 7, 1, 7);
    chk_cnt("halt", 0, 1, 1, 0, 1, 11, 1, 10);

    // Clear beats simultaneous increments.
    sv.hlt = 1'b0;
    drive(sv);
    tick();
    cnt_clr = 1'b0;
    for (int n = 0; n < 3; n++) chk_cnt("clr1", n, 0, 0, 0, 0, 0, 0, 0);

    // Async reset in the middle of a held stall; hazard re-counts after release.
    drive(lu);
    tick();
    chk_cnt("pre_rst", 0, 1, 1, 0, 1, 0, 0, 0);
    #2;
    clr = 1'b0;
    #1;
    chk("mid_rst.stalls", f_st, 5'b00000);
    chk("mid_rst.flushs", f_fl, 5'b00000);
    chk("mid_rst.dh", f_c[0], 32'd0);
    chk("mid_rst.sc", f_c[3], 32'd0);
    #1;
    clr = 1'b1;
    #1;
    chk("post_rst.stalls", f_st, 5'b00011);
    tick();
    chk_cnt("post_rst", 0, 1, 1, 0, 1, 0, 0, 0);
    chk_cnt("post_rst", 1, 1, 1, 0, 1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
